fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_pkg.sv | 19 +
 rtl/bin2gray.sv | 11 +
 rtl/gray2bin.sv | 13 +
 rtl/ptr_sync.sv | 30 +++
 rtl/fifo_rd_ctrl.sv | 129 ++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 200 ++++++++++++++++++++
 6 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer type used by the read/write controllers.
package fifo_pkg;

   // Gray encoding of a pointer whose binary value is all-ones: only the MSB set.
   function automatic logic [31:0] ptr_rst_gray(input int unsigned aw);
      return 32'(1) << aw;
   endfunction

   localparam int ADDR_W      = 3;
   localparam int PW          = ADDR_W + 1;
   localparam int SYNC_STAGES = 2;

   typedef logic [PW-1:0] ptr_t;

   // Pointers reset to binary all-ones so the first advance lands on entry 0.
   localparam ptr_t PTR_RST_BIN  = '1;
   localparam ptr_t PTR_RST_GRAY = PW'(ptr_rst_gray(ADDR_W));

endpackage

// File: rtl/bin2gray.sv
// Binary-to-Gray converter.
module bin2gray #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_bin,
   output logic [W-1:0] o_gray
);

   assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_gray,
   output logic [W-1:0] o_bin
);

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign o_bin[i] = ^i_gray[W-1:i];
   end

endmodule

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the clk domain.
// The chain is a plain shift of whole words: no logic between stages, so only
// one bit can be in flight per Gray step. STAGES must be 2..4.
module ptr_sync
   import fifo_pkg::*;
#(
   parameter int             W       = PW,
   parameter int             STAGES  = SYNC_STAGES,
   parameter logic [W-1:0]   RST_VAL = W'(PTR_RST_GRAY)
) (
   input  logic         clk,
   input  logic         resetb,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [STAGES-1:0][W-1:0] r_sync;

   // Shift the incoming pointer one stage per clock; reset every stage to the pointer reset code.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_sync <= {STAGES{RST_VAL}};
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: Gray read pointer, write-pointer
// synchronizer, and registered empty / almost-empty / level / underflow flags.
// Reset deassertion is expected to arrive already synchronized to clk.
module fifo_rd_ctrl #(
   parameter int ADDR_W      = fifo_pkg::ADDR_W,
   parameter int SYNC_STAGES = fifo_pkg::SYNC_STAGES,
   parameter int AE_THRESH   = 2
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic [ADDR_W:0]   wr_ptr_gray,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   rd_ptr_gray,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   rd_level,
   output logic              underflow
);

   import fifo_pkg::*;

   localparam int                PTR_W    = ADDR_W + 1;
   localparam logic [PTR_W-1:0] RST_GRAY = PTR_W'(ptr_rst_gray(ADDR_W));
   localparam logic [PTR_W-1:0] DEPTH_P  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [PTR_W-1:0] AE_P     = PTR_W'(AE_THRESH);

   logic [PTR_W-1:0]  r_rd_gray;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_empty;
   logic              r_ae;
   logic [PTR_W-1:0]  r_level;
   logic              r_uf;

   logic              w_pop;
   logic [PTR_W-1:0]  w_rd_bin;
   logic [PTR_W-1:0]  w_rd_bin_next;
   logic [PTR_W-1:0]  w_rd_gray_next;
   logic [PTR_W-1:0]  w_wr_gray_s;
   logic [PTR_W-1:0]  w_wr_bin_s;
   logic [PTR_W-1:0]  w_level_raw;
   logic [PTR_W-1:0]  w_level_d;

   // Write pointer into the read domain.
   ptr_sync #(
      .W       (PTR_W),
      .STAGES  (SYNC_STAGES),
      .RST_VAL (RST_GRAY)
   ) u_wr_sync (
      .clk    (clk),
      .resetb (resetb),
      .i_d    (wr_ptr_gray),
      .o_q    (w_wr_gray_s)
   );

   gray2bin #(.W(PTR_W)) u_wr_g2b (
      .i_gray (w_wr_gray_s),
      .o_bin  (w_wr_bin_s)
   );

   gray2bin #(.W(PTR_W)) u_rd_g2b (
      .i_gray (r_rd_gray),
      .o_bin  (w_rd_bin)
   );

   // A pop only happens against a registered non-empty flag, so the pointer
   // can never run past the synchronized write pointer.
   assign w_pop         = ~r_empty & rd_ready;
   assign w_rd_bin_next = w_rd_bin + {{(PTR_W-1){1'b0}}, w_pop};

   bin2gray #(.W(PTR_W)) u_rd_b2g (
      .i_bin  (w_rd_bin_next),
      .o_gray (w_rd_gray_next)
   );

   // Level in modulo pointer arithmetic; the extra pointer bit resolves full vs empty.
   assign w_level_raw = w_wr_bin_s - w_rd_bin_next;

   // Clamp an impossible pointer pair to a full FIFO rather than reporting nonsense.
   always_comb begin
      w_level_d = w_level_raw;
      if (w_level_raw > DEPTH_P) begin
         w_level_d = DEPTH_P;
      end
   end

   // Read pointer and RAM address advance together on a pop.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_rd_gray <= RST_GRAY;
         r_rd_addr <= '1;
      end else begin
         r_rd_gray <= w_rd_gray_next;
         r_rd_addr <= w_rd_bin_next[ADDR_W-1:0];
      end
   end

   // Status flags from next-state pointers, so the last pop raises empty on its own edge.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_empty <= 1'b1;
         r_ae    <= 1'b1;
         r_level <= '0;
      end else begin
         r_empty <= (w_rd_gray_next == w_wr_gray_s);
         r_level <= w_level_d;
         r_ae    <= (w_level_d <= AE_P);
      end
   end

   // Flag a request that arrived while nothing was readable.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_uf <= 1'b0;
      end else begin
         r_uf <= rd_ready & r_empty;
      end
   end

   assign rd_ptr_gray  = r_rd_gray;
   assign rd_addr      = r_rd_addr;
   assign empty        = r_empty;
   assign rd_valid     = ~r_empty;
   assign almost_empty = r_ae;
   assign rd_level     = r_level;
   assign underflow    = r_uf;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: stimulus pushes expected outputs computed
// from entry counts; a monitor pops and compares one entry per clock.
module tb_fifo_rd_ctrl;

   localparam int AW    = 3;
   localparam int PW    = AW + 1;
   localparam int S     = 2;
   localparam int AE    = 2;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          resetb;
   logic [PW-1:0] wr_ptr_gray;
   logic          rd_ready;
   logic          rd_valid;
   logic [AW-1:0] rd_addr;
   logic [PW-1:0] rd_ptr_gray;
   logic          empty;
   logic          almost_empty;
   logic [PW-1:0] rd_level;
   logic          underflow;

   fifo_rd_ctrl #(
      .ADDR_W      (AW),
      .SYNC_STAGES (S),
      .AE_THRESH   (AE)
   ) dut (
      .clk          (clk),
      .resetb       (resetb),
      .wr_ptr_gray  (wr_ptr_gray),
      .rd_ready     (rd_ready),
      .rd_valid     (rd_valid),
      .rd_addr      (rd_addr),
      .rd_ptr_gray  (rd_ptr_gray),
      .empty        (empty),
      .almost_empty (almost_empty),
      .rd_level     (rd_level),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit valid;
      bit emp;
      bit ae;
      int level;
      int addr;
      int gray;
      bit uf;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference model: counts of entries written, visible and popped.
   int m_wcnt;
   int m_rcnt;
   int m_hist[$];
   bit m_empty;

   function automatic int g(input int b);
      return (b ^ (b >> 1)) & 15;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   task automatic check_rst(input string tag);
      chk({tag, "_empty"}, int'(empty), 1);
      chk({tag, "_valid"}, int'(rd_valid), 0);
      chk({tag, "_level"}, int'(rd_level), 0);
      chk({tag, "_ae"}, int'(almost_empty), 1);
      chk({tag, "_gray"}, int'(rd_ptr_gray), 8);
      chk({tag, "_addr"}, int'(rd_addr), 7);
      chk({tag, "_uf"}, int'(underflow), 0);
   endtask

   task automatic model_reset();
      m_wcnt  = 0;
      m_rcnt  = 0;
      m_empty = 1'b1;
      m_hist.delete();
      for (int i = 0; i < S; i++) m_hist.push_back(0);
      exp_q.delete();
   endtask

   // One clock of stimulus: optionally write one entry (if room) and set rd_ready.
   task automatic step(input bit rdy, input bit wr);
      exp_t e;
      int   vis;
      int   lvl;
      bit   pop;
      @(negedge clk);
      if (wr && (m_wcnt - m_rcnt) < DEPTH) m_wcnt++;
      wr_ptr_gray = 4'(g((m_wcnt - 1) & 15));
      rd_ready    = rdy;
      pop  = !m_empty && rdy;
      e.uf = rdy && m_empty;
      if (pop) m_rcnt++;
      // A write becomes visible to the empty/level logic S+1 edges after it is driven.
      m_hist.push_back(m_wcnt);
      vis = m_hist[0];
      m_hist.pop_front();
      lvl     = vis - m_rcnt;
      m_empty = (lvl == 0);
      e.valid = !m_empty;
      e.emp   = m_empty;
      e.ae    = (lvl <= AE);
      e.level = lvl;
      e.addr  = (m_rcnt - 1) & 7;
      e.gray  = g((m_rcnt - 1) & 15);
      exp_q.push_back(e);
   endtask

   // Monitor: compare every output once per clock against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_valid", int'(rd_valid), int'(e.valid));
            chk("empty", int'(empty), int'(e.emp));
            chk("almost_empty", int'(almost_empty), int'(e.ae));
            chk("rd_level", int'(rd_level), e.level);
            chk("rd_addr", int'(rd_addr), e.addr);
            chk("rd_ptr_gray", int'(rd_ptr_gray), e.gray);
            chk("underflow", int'(underflow), int'(e.uf));
         end
      end
   end

   initial begin
      resetb      = 1'b0;
      wr_ptr_gray = 4'b1000;
      rd_ready    = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_rst("in_reset");
      @(negedge clk);
      resetb = 1'b1;
      #1;
      check_rst("post_release");

      // Single write: visibility latency and level 1.
      step(1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0);
      // Fill to full, then drain all eight.
      repeat (7) step(1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0);
      repeat (8) step(1'b1, 1'b0);
      // Underflow for three cycles while empty.
      repeat (3) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      // Steady simultaneous push/pop across several pointer wraps.
      repeat (3) step(1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0);
      repeat (40) step(1'b1, 1'b1);
      // Random traffic.
      repeat (400) step($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      repeat (60) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);

      // Fill, settle, pop three to reach level 5, then reset between edges.
      repeat (8) step(1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0);
      @(negedge clk);
      #2;
      resetb = 1'b0;
      #1;
      check_rst("async_reset");
      exp_q.delete();
      wr_ptr_gray = 4'b1000;
      rd_ready    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetb = 1'b1;
      model_reset();
      #1;
      check_rst("post_reset2");

      // Normal operation resumes from scratch.
      repeat (150) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      step(1'b0, 1'b0);

      repeat (2) @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
